// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with one-word lines.
// Fills through a one-word memory handshake; supports a one-cycle invalidate and a miss counter.
module icache #(
    parameter int CACHE_SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        iflush,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] misscount
);
    localparam int IW = $clog2(CACHE_SETS);
    localparam int TW = 30 - IW;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FETCH = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [CACHE_SETS-1:0] valid_q, valid_d;
    logic [TW-1:0]         tag_q  [CACHE_SETS];
    logic [TW-1:0]         tag_d  [CACHE_SETS];
    logic [31:0]           data_q [CACHE_SETS];
    logic [31:0]           data_d [CACHE_SETS];
    logic [31:0]           missaddr_q, missaddr_d;
    logic                  discard_q, discard_d;
    logic [31:0]           misscount_q, misscount_d;

    logic [IW-1:0] req_idx, fill_idx;
    logic [TW-1:0] req_tag, fill_tag;
    logic [1:0]    unused_offset;

    assign req_idx       = imemaddr[IW+1:2];
    assign req_tag       = imemaddr[31:IW+2];
    assign fill_idx      = missaddr_q[IW+1:2];
    assign fill_tag      = missaddr_q[31:IW+2];
    assign unused_offset = imemaddr[1:0];

    always_comb begin
        ihit = (state_q == IDLE) && imemREN && valid_q[req_idx]
               && (tag_q[req_idx] == req_tag) && !iflush;
        imemload  = ihit ? data_q[req_idx] : '0;
        iREN      = (state_q == FETCH);
        iaddr     = missaddr_q;
        misscount = misscount_q;
    end

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        tag_d       = tag_q;
        data_d      = data_q;
        missaddr_d  = missaddr_q;
        discard_d   = discard_q;
        misscount_d = misscount_q;

        case (state_q)
            IDLE: begin
                if (imemREN && !ihit && !iflush) begin
                    missaddr_d  = {imemaddr[31:2], 2'b00};
                    misscount_d = misscount_q + 32'd1;
                    state_d     = FETCH;
                end
            end
            default: begin
                if (!iwait) begin
                    // A flush seen earlier in this fill, or in this very cycle, drops the fill.
                    if (!discard_q && !iflush) begin
                        valid_d[fill_idx] = 1'b1;
                        tag_d[fill_idx]   = fill_tag;
                        data_d[fill_idx]  = iload;
                    end
                    discard_d = 1'b0;
                    state_d   = IDLE;
                end else if (iflush) begin
                    discard_d = 1'b1;
                end
            end
        endcase

        if (iflush) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            missaddr_q  <= '0;
            discard_q   <= 1'b0;
            misscount_q <= '0;
            for (int unsigned i = 0; i < CACHE_SETS; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
            missaddr_q  <= missaddr_d;
            discard_q   <= discard_d;
            misscount_q <= misscount_d;
        end
    end
endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios followed by random traffic,
// checked against a line-level reference model of the cache.
module tb_icache;
    localparam int SETS = 16;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = '0;
    logic        iflush = 1'b0;
    logic        iwait = 1'b1;
    logic [31:0] iload = '0;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] misscount;

    always #5 CLK = ~CLK;

    icache #(.CACHE_SETS(SETS)) dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .iflush(iflush), .iREN(iREN),
        .iaddr(iaddr), .iwait(iwait), .iload(iload), .misscount(misscount)
    );

    // Reference model: each line remembers the full word address it holds.
    bit          mvalid [SETS];
    logic [29:0] mline  [SETS];
    logic [31:0] mdata  [SETS];
    bit          pend, pdisc;
    logic [31:0] paddr, mcount;

    int          vectors = 0;
    int          miscompares = 0;
    logic        obs_hit;
    logic [31:0] obs_load, obs_cnt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h10) return 32'h8C220004;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SETS; i++) begin
            mvalid[i] = 0;
            mline[i]  = '0;
            mdata[i]  = '0;
        end
        pend = 0; pdisc = 0; paddr = '0; mcount = '0;
    endtask

    task automatic step(input bit ren, input logic [31:0] addr, input bit fl, input bit wt);
        logic [29:0] wa;
        int unsigned idx, pidx;
        bit eh;
        @(negedge CLK);
        imemREN = ren; imemaddr = addr; iflush = fl; iwait = wt;
        #1 iload = mem_word(iaddr);
        #1;
        wa  = addr[31:2];
        idx = wa % SETS;
        eh  = !pend && ren && mvalid[idx] && (mline[idx] == wa) && !fl;
        obs_hit = ihit; obs_load = imemload; obs_cnt = misscount;
        check("ihit", {31'b0, ihit}, {31'b0, eh});
        check("imemload", imemload, eh ? mdata[idx] : 32'h0);
        check("iREN", {31'b0, iREN}, {31'b0, pend});
        check("iaddr", iaddr, paddr);
        check("misscount", misscount, mcount);
        if (pend) begin
            if (!wt) begin
                if (!pdisc && !fl) begin
                    pidx = paddr[31:2] % SETS;
                    mvalid[pidx] = 1;
                    mline[pidx]  = paddr[31:2];
                    mdata[pidx]  = mem_word(paddr);
                end
                pend = 0; pdisc = 0;
            end else if (fl) begin
                pdisc = 1;
            end
        end else if (ren && !eh && !fl) begin
            pend   = 1;
            paddr  = {addr[31:2], 2'b00};
            mcount = mcount + 32'd1;
        end
        if (fl) for (int i = 0; i < SETS; i++) mvalid[i] = 0;
        @(posedge CLK);
    endtask

    task automatic miss_fill(input logic [31:0] addr, input int waits);
        step(1, addr, 0, 1);
        repeat (waits) step(1, addr, 0, 1);
        step(1, addr, 0, 0);
    endtask

    task automatic do_reset(input int n);
        @(negedge CLK);
        nRST = 0; imemREN = 0; iflush = 0; iwait = 1;
        #1 model_reset();
        for (int i = 0; i < n; i++) begin
            check("rst_iREN", {31'b0, iREN}, 32'h0);
            check("rst_ihit", {31'b0, ihit}, 32'h0);
            check("rst_misscount", misscount, 32'h0);
            check("rst_iaddr", iaddr, 32'h0);
            @(negedge CLK);
            #1;
        end
        nRST = 1;
    endtask

    initial begin
        logic [31:0] base, ra;
        model_reset();

        do_reset(2);
        repeat (5) step(0, 32'h0, 0, 1);

        // Cold miss on 0x10 with three wait cycles, then hit.
        miss_fill(32'h10, 3);
        step(1, 32'h10, 0, 1);
        check("cold_hit", {31'b0, obs_hit}, 32'h1);
        check("cold_data", obs_load, 32'h8C220004);
        check("cold_count", obs_cnt, 32'h1);
        step(0, 32'h0, 0, 1);
        step(1, 32'h10, 0, 1);
        check("rehit", {31'b0, obs_hit}, 32'h1);

        // Conflict eviction on a shared index.
        base = obs_cnt;
        miss_fill(32'h0, 1);
        miss_fill(32'h40, 0);
        step(1, 32'h40, 0, 1);
        check("conflict_data", obs_load, mem_word(32'h40));
        miss_fill(32'h0, 2);
        step(1, 32'h0, 0, 1);
        check("conflict_count", obs_cnt - base, 32'd3);

        // Byte offset is ignored.
        miss_fill(32'h20, 0);
        step(1, 32'h23, 0, 1);
        check("offset_hit", {31'b0, obs_hit}, 32'h1);
        check("offset_data", obs_load, mem_word(32'h20));

        // Flush in the first fetch cycle discards the fill.
        do_reset(1);
        step(1, 32'h30, 0, 1);
        step(1, 32'h30, 1, 1);
        step(1, 32'h30, 0, 1);
        step(1, 32'h30, 0, 0);
        step(1, 32'h30, 0, 1);
        check("flush_remiss", {31'b0, obs_hit}, 32'h0);
        step(1, 32'h30, 0, 0);
        check("flush_count", obs_cnt, 32'd2);

        // Flush coinciding with fill completion.
        step(1, 32'h50, 0, 1);
        step(1, 32'h50, 1, 0);
        step(1, 32'h50, 0, 1);
        check("flush_same_cycle", {31'b0, obs_hit}, 32'h0);
        step(1, 32'h50, 0, 0);

        // Reset in the second fetch cycle.
        miss_fill(32'h10, 0);
        step(1, 32'h10, 0, 1);
        step(1, 32'h90, 0, 1);
        step(1, 32'h90, 0, 1);
        do_reset(1);
        step(1, 32'h10, 0, 1);
        check("reset_remiss", {31'b0, obs_hit}, 32'h0);

        // Random traffic over a small address window.
        repeat (400) begin
            ra = ($urandom_range(0, 3) << 6) | ($urandom_range(0, SETS - 1) << 2)
                 | $urandom_range(0, 3);
            step(($urandom_range(0, 7) != 0), ra, ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 2) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
